// File: rtl/audio_pcm_unpacker_if.sv
// rtl/audio_pcm_unpacker_if.sv - byte FIFO read port between audio FIFO and PCM unpacker
interface audio_pcm_unpacker_if;
  logic [7:0] fifo_rddata;
  logic       fifo_empty;
  logic       fifo_rd_en;

  modport master (input fifo_rddata, input fifo_empty, output fifo_rd_en);
  modport slave  (output fifo_rddata, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/audio_pcm_unpacker.sv
// rtl/audio_pcm_unpacker.sv - pulls 1/2/2/4 bytes per sample tick and assembles signed 16-bit L/R
module audio_pcm_unpacker (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_sample_tick,
  input  logic                         i_mode_16bit,
  input  logic                         i_mode_stereo,
  audio_pcm_unpacker_if.master         fifo,
  output logic [15:0]                  o_left,
  output logic [15:0]                  o_right,
  output logic                         o_sample_valid,
  output logic                         o_underrun,
  output logic                         o_tick_missed
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_GAP, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_empty_q;
  logic            r_m16;
  logic            r_mst;
  logic            r_uflag;
  logic [1:0]      r_idx;
  logic [3:0][7:0] r_slot;
  logic            w_pop;
  logic [1:0]      w_last;
  logic [15:0]     w_left;
  logic [15:0]     w_right;

  // index of the final byte of the frame: nbytes-1 for 1/2/2/4 bytes
  assign w_last = {r_m16 & r_mst, r_m16 | r_mst};

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  if (i_sample_tick) w_next = S_FETCH;
      S_FETCH: begin
        if (fifo.fifo_empty) begin
          w_next = S_DONE;
        end else if (!r_empty_q) begin
          w_pop  = 1'b1;
          w_next = (r_idx == w_last) ? S_DONE : S_GAP;
        end
      end
      S_GAP:   w_next = S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign fifo.fifo_rd_en = w_pop;

  // 8-bit samples sit in the MSBs; mono duplicates left onto right
  always_comb begin
    w_left  = r_m16 ? {r_slot[1], r_slot[0]} : {r_slot[0], 8'h00};
    w_right = w_left;
    if (r_mst) w_right = r_m16 ? {r_slot[3], r_slot[2]} : {r_slot[1], 8'h00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_empty_q      <= 1'b1;
      r_m16          <= 1'b0;
      r_mst          <= 1'b0;
      r_uflag        <= 1'b0;
      r_idx          <= 2'd0;
      r_slot         <= '0;
      o_left         <= 16'h0000;
      o_right        <= 16'h0000;
      o_sample_valid <= 1'b0;
      o_underrun     <= 1'b0;
      o_tick_missed  <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_empty_q      <= fifo.fifo_empty;
      o_tick_missed  <= i_sample_tick && (r_state != S_IDLE);
      o_sample_valid <= (r_state == S_DONE);
      o_underrun     <= (r_state == S_DONE) && r_uflag;
      case (r_state)
        S_IDLE: begin
          if (i_sample_tick) begin
            r_m16   <= i_mode_16bit;
            r_mst   <= i_mode_stereo;
            r_idx   <= 2'd0;
            r_uflag <= 1'b0;
          end
        end
        S_FETCH: begin
          if (fifo.fifo_empty) begin
            r_uflag <= 1'b1;
          end else if (w_pop) begin
            r_slot[r_idx] <= fifo.fifo_rddata;
            r_idx         <= r_idx + 2'd1;
          end
        end
        S_DONE: begin
          o_left  <= r_uflag ? 16'h0000 : w_left;
          o_right <= r_uflag ? 16'h0000 : w_right;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_pcm_unpacker.sv
// tb/tb_audio_pcm_unpacker.sv - directed self-checking bench for audio_pcm_unpacker
module tb_audio_pcm_unpacker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        m16 = 1'b0;
  logic        mst = 1'b0;
  logic [15:0] left, right;
  logic        valid, underrun, missed;
  int          errors = 0;
  int          checks = 0;

  // byte FIFO model with a registered read port
  logic [7:0]  mem [16];
  logic [4:0]  wp = 5'd0;
  logic [4:0]  rp = 5'd0;
  logic        wr = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdq = 8'h00;

  audio_pcm_unpacker_if fif ();

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      wp <= 5'd0;
      rp <= 5'd0;
    end else begin
      if (wr) begin
        mem[wp[3:0]] <= wdata;
        wp <= wp + 5'd1;
      end
      if (fif.fifo_rd_en) rp <= rp + 5'd1;
    end
    rdq <= mem[rp[3:0]];
  end

  assign fif.fifo_rddata = rdq;
  assign fif.fifo_empty  = (wp == rp);

  audio_pcm_unpacker dut (
    .clk(clk), .rst(rst), .i_sample_tick(tick), .i_mode_16bit(m16), .i_mode_stereo(mst),
    .fifo(fif), .o_left(left), .o_right(right), .o_sample_valid(valid),
    .o_underrun(underrun), .o_tick_missed(missed)
  );

  task automatic fifo_clear();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; wdata = b;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // k counts edges after the one that sampled the tick; returns at the valid cycle
  task automatic run_frame(input logic a16, input logic ast, input logic flip_mode,
                           input logic push_now, input logic [7:0] pbyte,
                           output int lat, output int pops, output int first_pop, output int min_gap);
    int last_pop;
    bit done;
    lat = -1; pops = 0; first_pop = -1; min_gap = 99; last_pop = -100; done = 0;
    @(negedge clk);
    tick = 1'b1; m16 = a16; mst = ast;
    if (push_now) begin wr = 1'b1; wdata = pbyte; end
    @(negedge clk);
    tick = 1'b0; wr = 1'b0;
    if (flip_mode) begin m16 = ~a16; mst = ~ast; end
    for (int k = 0; k < 40 && !done; k++) begin
      if (valid) begin
        lat = k;
        done = 1;
      end else begin
        if (fif.fifo_rd_en) begin
          pops++;
          if (first_pop < 0) first_pop = k;
          if (k - last_pop < min_gap) min_gap = k - last_pop;
          last_pop = k;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (fif.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fif.fifo_rd_en); end
    checks++; if ({left, right} !== 32'h0) begin errors++; $display("FAIL reset_lr: got %h/%h expected 0000/0000", left, right); end
    checks++; if ({valid, underrun, missed} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {valid, underrun, missed}); end
    rst = 1'b0;
    fifo_clear();
  endtask

  task automatic test_mono8();
    int lat, pops, fp, mg;
    push(8'h80); settle();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, lat, pops, fp, mg);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mono8_latency: got %0d expected 2", lat); end
    checks++; if (pops !== 1) begin errors++; $display("FAIL mono8_pops: got %0d expected 1", pops); end
    checks++; if ({left, right} !== 32'h8000_8000) begin errors++; $display("FAIL mono8_lr: got %h/%h expected 8000/8000", left, right); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mono8_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_stereo16();
    int lat, pops, fp, mg;
    push(8'h34); push(8'h12); push(8'h78); push(8'h56); settle();
    run_frame(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, lat, pops, fp, mg);
    checks++; if (lat !== 8) begin errors++; $display("FAIL st16_latency: got %0d expected 8", lat); end
    checks++; if (pops !== 4) begin errors++; $display("FAIL st16_pops: got %0d expected 4", pops); end
    checks++; if (mg !== 2) begin errors++; $display("FAIL st16_pop_gap: got %0d expected 2", mg); end
    checks++; if ({left, right} !== 32'h1234_5678) begin errors++; $display("FAIL st16_lr: got %h/%h expected 1234/5678", left, right); end
  endtask

  task automatic test_underrun();
    int lat, pops, fp, mg;
    push(8'h34); push(8'h12); settle();
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, lat, pops, fp, mg);
    checks++; if (lat !== 6) begin errors++; $display("FAIL ur_latency: got %0d expected 6", lat); end
    checks++; if (pops !== 2) begin errors++; $display("FAIL ur_pops: got %0d expected 2", pops); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b expected 1", underrun); end
    checks++; if ({left, right} !== 32'h0) begin errors++; $display("FAIL ur_lr: got %h/%h expected 0000/0000", left, right); end
    checks++; if (fif.fifo_empty !== 1'b1) begin errors++; $display("FAIL ur_fifo_empty: got %b expected 1", fif.fifo_empty); end
    @(negedge clk);
    checks++; if ({valid, underrun} !== 2'b00) begin errors++; $display("FAIL ur_pulse_width: got %b expected 00", {valid, underrun}); end
  endtask

  task automatic test_stall();
    int lat, pops, fp, mg;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, lat, pops, fp, mg);
    checks++; if (fp !== 1) begin errors++; $display("FAIL stall_first_pop: got %0d expected 1", fp); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL stall_latency: got %0d expected 3", lat); end
    checks++; if ({left, right, underrun} !== 33'h0_4000_4000 >> 0 << 1 >> 1) begin end
    checks++; if ({left, right} !== 32'h4000_4000) begin errors++; $display("FAIL stall_lr: got %h/%h expected 4000/4000", left, right); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL stall_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_tick_missed();
    int seen = 0;
    push(8'h11); push(8'h22); settle();
    @(negedge clk); tick = 1'b1; m16 = 1'b0; mst = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_pulse: got %b expected 1", missed); end
    @(negedge clk);
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL missed_width: got %b expected 0", missed); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL missed_valid: got %b expected 1", valid); end
    checks++; if ({left, right} !== 32'h1100_2200) begin errors++; $display("FAIL missed_lr: got %h/%h expected 1100/2200", left, right); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL missed_no_extra_frame: got %0d frames expected 0", seen); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, pops, fp, mg;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD); settle();
    @(negedge clk); tick = 1'b1; m16 = 1'b1; mst = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (fif.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre_pop: got %b expected 1", fif.fifo_rd_en); end
    rst = 1'b1;
    #1;
    checks++; if (fif.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b expected 0", fif.fifo_rd_en); end
    checks++; if ({left, right} !== 32'h0) begin errors++; $display("FAIL rstmid_lr: got %h/%h expected 0000/0000", left, right); end
    @(negedge clk); rst = 1'b0;
    settle();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, lat, pops, fp, mg);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
    checks++; if ({left, right} !== 32'hCCBB_CCBB) begin errors++; $display("FAIL rstmid_lr_after: got %h/%h expected CCBB/CCBB", left, right); end
    fifo_clear();
  endtask

  initial begin
    test_reset();
    test_mono8();
    test_stereo16();
    test_underrun();
    test_stall();
    test_tick_missed();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
